// File: rtl/ld_buffer.sv
// rtl/ld_buffer.sv - load-data buffer between the vector AGU and the lane, with credit-based stall.
module ld_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              I_Req,
  input  logic [ADDR_W-1:0] I_Address,
  input  logic              I_End_Access,
  output logic              O_Stall,
  output logic              O_Mem_Req,
  output logic [ADDR_W-1:0] O_Mem_Addr,
  input  logic              I_Mem_Rd_Valid,
  input  logic [DATA_W-1:0] I_Mem_Rd_Data,
  output logic              O_Valid,
  output logic [DATA_W-1:0] O_Data,
  input  logic              I_Ready,
  output logic              O_Done,
  output logic              O_Error
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     credit_q, credit_d;
  logic [CW-1:0]     out_q, out_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] fifo_q [DEPTH];
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              error_q, error_d;
  logic              done;
  logic              stall, empty, accept, pop, push;

  // Credits reserve a FIFO slot at Accept, so the stall never depends on I_Req.
  assign stall  = (credit_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign accept = I_Req & ~stall;
  assign pop    = ~empty & I_Ready;
  assign push   = I_Mem_Rd_Valid & (out_q != '0);

  always_comb begin
    credit_d = credit_q;
    if (accept && !pop)      credit_d = credit_q + 1'b1;
    else if (!accept && pop) credit_d = credit_q - 1'b1;

    out_d = out_q;
    if (mem_req_q && !push)      out_d = out_q + 1'b1;
    else if (!mem_req_q && push) out_d = out_q - 1'b1;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (I_End_Access) state_d = S_DRAIN;
        else if (accept)  state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (I_End_Access) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (credit_q == '0 && out_q == '0) begin
          state_d = S_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign error_d = error_q
                 | (I_Req & stall)
                 | (I_Mem_Rd_Valid & (out_q == '0))
                 | (accept & (state_q == S_DRAIN));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      credit_q   <= '0;
      out_q      <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      out_q     <= out_d;
      count_q   <= count_d;
      mem_req_q <= accept;
      error_q   <= error_d;
      if (accept) mem_addr_q <= I_Address;
      if (push)   wr_ptr_q   <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q   <= rd_ptr_q + 1'b1;
    end
  end

  // Data array is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= I_Mem_Rd_Data;
  end

  assign O_Stall    = stall;
  assign O_Mem_Req  = mem_req_q;
  assign O_Mem_Addr = mem_addr_q;
  assign O_Valid    = ~empty;
  assign O_Data     = empty ? '0 : fifo_q[rd_ptr_q];
  assign O_Done     = done;
  assign O_Error    = error_q;

endmodule
